edge_binarize: RTL and testbench
================================

EDGE_BINARIZE -- requirements
Module: edge_binarize

Interface
REQ-001 SHALL have parameter IMAGE_W, default 640, active pixels per line.
REQ-002 SHALL have parameter IMAGE_H, default 480, active lines per frame.
REQ-003 SHALL have parameter IMAGE_DW, default 8, pixel data width.
REQ-004 SHALL have port InVideoClk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port InVideoRstN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port InVideoVs  input  1  frame sync from the Sobel stage; a rising edge marks frame start.
REQ-007 SHALL have port InVideoDe  input  1  data enable; pixel valid when high.
REQ-008 SHALL have port InVideoData  input  IMAGE_DW  Sobel gradient magnitude.
REQ-009 SHALL have port InThreshold  input  IMAGE_DW  binarization threshold, sampled per frame.
REQ-010 SHALL have port OutVideoVs  output  1  InVideoVs delayed 1 cycle.
REQ-011 SHALL have port OutVideoDe  output  1  binarized pixel valid.
REQ-012 SHALL have port OutVideoData  output  IMAGE_DW  binary edge pixel, all-ones or zero.
REQ-013 SHALL have port OutEdgeCount  output  20  edge pixels in the last completed frame.
REQ-014 SHALL have port OutEdgeCountValid  output  1  one-cycle pulse when OutEdgeCount updates.
REQ-015 SHALL have port OutFrameErr  output  1  geometry error flag for the last completed frame, valid with OutEdgeCountValid.

Function
REQ-016 SHALL detect frame start as InVideoVs high in the current cycle and low in the previous cycle (registered edge detect).
REQ-017 SHALL implement states WAIT_SYNC (reset state; input ignored) and ACTIVE; WAIT_SYNC->ACTIVE on the first frame start; ACTIVE stays in ACTIVE across frames.
REQ-018 SHALL latch InThreshold into an internal threshold register on every frame start; a mid-frame InThreshold change SHALL NOT affect the current frame.
REQ-019 SHALL, in ACTIVE, output OutVideoDe = InVideoDe and OutVideoData = all-ones if InVideoData >= latched threshold, else zero, with exactly 1 cycle latency.
REQ-020 SHALL, in WAIT_SYNC, hold OutVideoDe = 0 and OutVideoData = 0; OutVideoVs SHALL track InVideoVs at 1-cycle delay in both states.
REQ-021 SHALL treat a pixel with InVideoDe high in the frame-start cycle as the first pixel of the new frame: it uses the newly latched threshold and counts into the new frame.
REQ-022 SHALL count accepted pixels per line in a column counter, clear it on InVideoDe falling edge and on frame start.
REQ-023 SHALL, on InVideoDe falling edge, increment a line counter and set an internal error bit if the column count != IMAGE_W.
REQ-024 SHALL increment a 20-bit edge counter for each output pixel equal to all-ones, saturating at 2^20-1.
REQ-025 SHALL, on each frame start while in ACTIVE (not the WAIT_SYNC->ACTIVE transition), load OutEdgeCount with the edge counter, set OutFrameErr = error bit OR (line count != IMAGE_H), pulse OutEdgeCountValid for 1 cycle, then clear edge counter, line counter, column counter and error bit.
REQ-026 SHALL, if InVideoDe is still high at frame start, include the unterminated line in neither the error check nor the line count of the finishing frame.
REQ-027 SHALL hold OutEdgeCount and OutFrameErr stable between updates.

Reset
REQ-028 SHALL, while InVideoRstN is low, force state WAIT_SYNC and all outputs, counters, threshold and edge-detect registers to 0, independent of the clock.
REQ-029 SHALL, after reset deassertion mid-frame, discard the remainder of that frame and produce no OutEdgeCountValid until the second frame start.

Verification
REQ-030 SHALL pass: threshold 128, one 640x480 frame of alternating 127/128 pixels, then Vs rise -> output alternates 0/255 at 1-cycle latency; OutEdgeCount = 153600, OutFrameErr = 0, one-cycle valid pulse.
REQ-031 SHALL pass: frame with line 10 only 639 pixels -> OutFrameErr = 1 at next frame start; following correct frame -> OutFrameErr = 0.
REQ-032 SHALL pass: frame of 479 lines, all pixels 255, threshold 0 -> OutEdgeCount = 306560, OutFrameErr = 1.
REQ-033 SHALL pass: InThreshold changed 200->50 mid-frame, all pixels 100 -> remainder of frame outputs 0; next frame outputs 255.
REQ-034 SHALL pass: pixels presented before the first Vs rise -> OutVideoDe stays 0; first Vs rise -> no OutEdgeCountValid.
REQ-035 SHALL pass: InVideoRstN low for 1 cycle mid-frame -> all outputs 0 immediately; no valid pulse at next Vs rise; valid pulse at the one after.

Source files
------------

// File: rtl/edge_binarize.sv
// rtl/edge_binarize.sv - thresholds Sobel magnitudes to a binary edge map and reports per-frame edge count and geometry errors
module edge_binarize #(
  parameter int IMAGE_W  = 640,
  parameter int IMAGE_H  = 480,
  parameter int IMAGE_DW = 8
) (
  input  logic                InVideoClk,
  input  logic                InVideoRstN,
  input  logic                InVideoVs,
  input  logic                InVideoDe,
  input  logic [IMAGE_DW-1:0] InVideoData,
  input  logic [IMAGE_DW-1:0] InThreshold,
  output logic                OutVideoVs,
  output logic                OutVideoDe,
  output logic [IMAGE_DW-1:0] OutVideoData,
  output logic [19:0]         OutEdgeCount,
  output logic                OutEdgeCountValid,
  output logic                OutFrameErr
);

  // Counters saturate one past their nominal size so an overlong line/frame never wraps back to "correct".
  localparam int CW = $clog2(IMAGE_W + 2);
  localparam int LW = $clog2(IMAGE_H + 3);
  localparam logic [CW-1:0] COL_MAX  = CW'(IMAGE_W + 1);
  localparam logic [LW-1:0] LINE_MAX = LW'(IMAGE_H + 1);

  typedef enum logic {WAIT_SYNC, ACTIVE} state_t;

  state_t              state, state_nxt;
  logic                vs_d, de_d;
  logic [IMAGE_DW-1:0] thr;
  logic [CW-1:0]       col;
  logic [LW-1:0]       lines;
  logic                err;
  logic [19:0]         edge_cnt;

  logic                frame_start, in_frame, rollover;
  logic [IMAGE_DW-1:0] thr_eff;
  logic                pix_ok, pix_edge, de_fall, err_fin;
  logic [LW-1:0]       lines_fin;

  assign frame_start = InVideoVs & ~vs_d;

  always_comb begin
    state_nxt = state;
    in_frame  = 1'b0;
    rollover  = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (frame_start) begin
          state_nxt = ACTIVE;
          in_frame  = 1'b1;
        end
      end
      ACTIVE: begin
        in_frame = 1'b1;
        rollover = frame_start;
      end
      default: state_nxt = WAIT_SYNC;
    endcase
  end

  // A pixel arriving with the sync edge already belongs to the new frame and its threshold.
  assign thr_eff   = frame_start ? InThreshold : thr;
  assign pix_ok    = in_frame & InVideoDe;
  assign pix_edge  = pix_ok & (InVideoData >= thr_eff);
  assign de_fall   = (state == ACTIVE) & de_d & ~InVideoDe;
  assign err_fin   = err | (de_fall & (col != CW'(IMAGE_W)));
  assign lines_fin = lines + LW'(de_fall);

  always_ff @(posedge InVideoClk or negedge InVideoRstN) begin
    if (!InVideoRstN) state <= WAIT_SYNC;
    else              state <= state_nxt;
  end

  always_ff @(posedge InVideoClk or negedge InVideoRstN) begin
    if (!InVideoRstN) begin
      vs_d              <= 1'b0;
      de_d              <= 1'b0;
      thr               <= '0;
      col               <= '0;
      lines             <= '0;
      err               <= 1'b0;
      edge_cnt          <= '0;
      OutVideoVs        <= 1'b0;
      OutVideoDe        <= 1'b0;
      OutVideoData      <= '0;
      OutEdgeCount      <= '0;
      OutEdgeCountValid <= 1'b0;
      OutFrameErr       <= 1'b0;
    end else begin
      vs_d              <= InVideoVs;
      de_d              <= InVideoDe;
      OutVideoVs        <= InVideoVs;
      OutVideoDe        <= pix_ok;
      OutVideoData      <= pix_edge ? '1 : '0;
      OutEdgeCountValid <= rollover;
      if (frame_start) thr <= InThreshold;
      if (rollover) begin
        OutEdgeCount <= edge_cnt;
        OutFrameErr  <= err_fin | (lines_fin != LW'(IMAGE_H));
      end
      if (frame_start) begin
        edge_cnt <= 20'(pix_edge);
        lines    <= '0;
        err      <= 1'b0;
        col      <= pix_ok ? CW'(1) : '0;
      end else if (state == ACTIVE) begin
        if (pix_edge && edge_cnt != 20'hF_FFFF) edge_cnt <= edge_cnt + 20'd1;
        if (de_fall) begin
          if (lines != LINE_MAX) lines <= lines + LW'(1);
          err <= err_fin;
          col <= '0;
        end else if (pix_ok && col != COL_MAX) begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_binarize.sv
// tb/tb_edge_binarize.sv - randomized scoreboard bench for edge_binarize on a reduced 16x6 image
module tb_edge_binarize;
  localparam int W  = 16;
  localparam int H  = 6;
  localparam int DW = 8;

  logic          clk = 1'b0, rst_n = 1'b0, vs = 1'b0, de = 1'b0;
  logic [DW-1:0] din = '0, thr_in = '0;
  logic          out_vs, out_de, out_valid, out_err;
  logic [DW-1:0] out_data;
  logic [19:0]   out_count;

  edge_binarize #(.IMAGE_W(W), .IMAGE_H(H), .IMAGE_DW(DW)) dut (
    .InVideoClk(clk), .InVideoRstN(rst_n), .InVideoVs(vs), .InVideoDe(de),
    .InVideoData(din), .InThreshold(thr_in), .OutVideoVs(out_vs), .OutVideoDe(out_de),
    .OutVideoData(out_data), .OutEdgeCount(out_count), .OutEdgeCountValid(out_valid),
    .OutFrameErr(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int cyc; } pix_t;
  typedef struct { int count; bit err; int cyc; } rpt_t;
  pix_t pix_q[$];
  rpt_t rpt_q[$];

  int checks = 0, failures = 0;
  bit active = 0, armed = 0, fr_err = 0, next_geo_err = 0, held_err = 0;
  int thr_frame = 0, fr_count = 0, held_count = 0;
  logic vs_smp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Frame boundary: report the finished frame (if one was fully tracked) and start the next.
  task automatic frame_start();
    if (armed) rpt_q.push_back(rpt_t'{fr_count, fr_err, cyc + 1});
    armed     = 1;
    active    = 1;
    thr_frame = thr_in;
    fr_count  = 0;
    fr_err    = next_geo_err;
  endtask

  task automatic idle(input bit v);
    @(posedge clk); #1;
    vs = v; de = 1'b0;
    if (v) frame_start();
  endtask

  task automatic pixel(input bit v, input int x);
    bit e;
    @(posedge clk); #1;
    vs = v; de = 1'b1; din = x[7:0];
    if (v) frame_start();
    if (active) begin
      e = (x >= thr_frame);
      pix_q.push_back(pix_t'{e ? 8'hFF : 8'h00, cyc + 1});
      if (e) fr_count++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; vs = 1'b0;
    #1;
    pix_q.delete(); rpt_q.delete();
    active = 0; armed = 0; held_count = 0; held_err = 0;
    check("rst_de", out_de, 0);
    check("rst_data", out_data, 0);
    check("rst_vs", out_vs, 0);
    check("rst_count", out_count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err", out_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic int gen(input int mode, input int p);
    case (mode)
      0:       return (p % 2) ? 128 : 127;
      1:       return 255;
      2:       return 100;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic send_frame(input int nlines, input int short_line, input int mode,
                            input int thr, input int thr2, input bit vs_on_pixel, input int rst_line);
    int w;
    next_geo_err = (nlines != H) || (short_line >= 0);
    thr_in = thr[7:0];
    if (!vs_on_pixel) begin
      idle(1); idle(0); idle(0);
    end
    for (int l = 0; l < nlines; l++) begin
      w = (l == short_line) ? W - 1 : W;
      if (l == nlines / 2) thr_in = thr2[7:0];
      for (int p = 0; p < w; p++) begin
        if (l == rst_line && p == 3) do_reset();
        pixel(vs_on_pixel && l == 0 && p == 0, gen(mode, p));
      end
      idle(0); idle(0); idle(0);
    end
  endtask

  always @(posedge clk) vs_smp <= vs;

  always @(negedge clk) begin
    if (rst_n) begin
      pix_t p;
      rpt_t r;
      check("vs_delay", out_vs, vs_smp);
      if (out_de) begin
        if (pix_q.size() == 0) check("unexpected_de", 1, 0);
        else begin
          p = pix_q.pop_front();
          check("pix_data", out_data, p.data);
          check("pix_latency", cyc, p.cyc);
        end
      end else begin
        if (out_data != 0) check("data_without_de", out_data, 0);
        if (pix_q.size() > 0 && pix_q[0].cyc <= cyc) begin
          check("missing_de", 0, 1);
          void'(pix_q.pop_front());
        end
      end
      if (out_valid) begin
        if (rpt_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          r = rpt_q.pop_front();
          check("edge_count", out_count, r.count);
          check("frame_err", out_err, r.err);
          check("report_latency", cyc, r.cyc);
          held_count = r.count;
          held_err   = r.err;
        end
      end else begin
        check("count_hold", out_count, held_count);
        check("err_hold", out_err, held_err);
        if (rpt_q.size() > 0 && rpt_q[0].cyc <= cyc) begin
          check("missing_valid", 0, 1);
          void'(rpt_q.pop_front());
        end
      end
    end
  end

  initial begin
    int nl, sl, t1, t2;
    repeat (3) @(posedge clk);
    #1;
    check("init_de", out_de, 0);
    check("init_count", out_count, 0);
    check("init_valid", out_valid, 0);
    rst_n = 1'b1;

    // Pixels before any sync must be ignored.
    for (int p = 0; p < W; p++) pixel(0, 200);
    idle(0); idle(0); idle(0);

    send_frame(H, -1, 0, 128, 128, 0, -1);
    send_frame(H, -1, 0, 128, 128, 0, -1);
    send_frame(H,  2, 1,   0,   0, 0, -1);
    send_frame(H, -1, 2, 200,  50, 0, -1);
    send_frame(H, -1, 2,  50,  50, 1, -1);
    send_frame(H - 1, -1, 1, 0, 0, 0, -1);
    send_frame(H, -1, 3, 90, 160, 0, 2);
    send_frame(H, -1, 1,  0,   0, 0, -1);
    send_frame(H, -1, 3, 60,  60, 0, -1);
    for (int i = 0; i < 6; i++) begin
      nl = H - 1 + int'($urandom_range(0, 2));
      sl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      t1 = int'($urandom_range(0, 255));
      t2 = int'($urandom_range(0, 255));
      send_frame(nl, sl, 3, t1, t2, i[0], -1);
    end

    idle(1);
    repeat (6) idle(0);
    check("pix_queue_drained", pix_q.size(), 0);
    check("rpt_queue_drained", rpt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
